// File: rtl/sample_scheduler_if.sv
// Stream interface of the sample scheduler: deserializer-side input, modulator-side
// output and sticky status.
interface sample_scheduler_if #(
   parameter int unsigned W         = 24,
   parameter int unsigned depthBits = 4
);
   logic                 enable;
   logic                 inAvailable;
   logic [W-1:0]         inData;
   logic                 clearFlags;
   logic [W-1:0]         outData;
   logic                 outStrobe;
   logic [depthBits:0]   level;
   logic                 underrun;
   logic                 overflow;
   logic                 running;

   modport master (
      output enable, inAvailable, inData, clearFlags,
      input  outData, outStrobe, level, underrun, overflow, running
   );

   modport slave (
      input  enable, inAvailable, inData, clearFlags,
      output outData, outStrobe, level, underrun, overflow, running
   );
endinterface

// File: rtl/sample_scheduler.sv
// Buffers bursty samples from the deserializer and releases them to the carrier
// phase-delta adder at a fixed rate, with prefill, underrun recovery and overflow flags.
module sample_scheduler #(
   parameter int unsigned clockRate    = 76_800_000,
   parameter int unsigned sampleRate   = 48_000,
   parameter int unsigned blockSize    = 3,
   parameter int unsigned depthBits    = 4,
   parameter int unsigned prefillLevel = 8
) (
   input logic               clk,
   input logic               reset,
   sample_scheduler_if.slave bus
);
   localparam int unsigned W           = 8 * blockSize;
   localparam int unsigned divider     = clockRate / sampleRate;
   localparam int unsigned dividerLast = divider - 1;
   localparam int unsigned cntBits     = $clog2(divider);
   localparam int unsigned depth       = 1 << depthBits;

   localparam logic [W-1:0]         centre     = {1'b1, {(W-1){1'b0}}};
   localparam logic [cntBits-1:0]   tickLast   = dividerLast[cntBits-1:0];
   localparam logic [depthBits:0]   depthLevel = depth[depthBits:0];
   localparam logic [depthBits:0]   prefillLvl = prefillLevel[depthBits:0];

   typedef enum logic [1:0] {StIdle, StPrefill, StRun} stateType;

   stateType               state;
   logic [cntBits-1:0]     tickCount;
   logic [depthBits-1:0]   wrPtr;
   logic [depthBits-1:0]   rdPtr;
   logic [depthBits:0]     count;
   logic [W-1:0]           mem [depth];
   logic [W-1:0]           outDataQ;
   logic                   outStrobeQ;
   logic                   underrunQ;
   logic                   overflowQ;
   logic                   runningQ;

   logic tick;
   logic empty;
   logic full;
   logic doPop;
   logic doPush;
   logic setUnder;
   logic setOver;

   always_comb begin
      tick     = (tickCount == tickLast);
      empty    = (count == '0);
      full     = (count == depthLevel);
      doPop    = (state == StRun) && tick && !empty;
      // A pop in the same cycle frees the slot, so a full FIFO can still accept.
      doPush   = bus.inAvailable && (state != StIdle) && (!full || doPop);
      setUnder = (state == StRun) && tick && empty;
      setOver  = bus.inAvailable && (state != StIdle) && full && !doPop;
   end

   always_ff @(posedge clk) begin
      if (doPush) begin
         mem[wrPtr] <= bus.inData;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= StIdle;
         tickCount  <= '0;
         wrPtr      <= '0;
         rdPtr      <= '0;
         count      <= '0;
         outDataQ   <= centre;
         outStrobeQ <= 1'b0;
         underrunQ  <= 1'b0;
         overflowQ  <= 1'b0;
         runningQ   <= 1'b0;
      end else begin
         tickCount  <= tick ? '0 : tickCount + 1'b1;
         outStrobeQ <= 1'b0;

         if (setUnder) begin
            underrunQ <= 1'b1;
         end else if (bus.clearFlags) begin
            underrunQ <= 1'b0;
         end
         if (setOver) begin
            overflowQ <= 1'b1;
         end else if (bus.clearFlags) begin
            overflowQ <= 1'b0;
         end

         if (!bus.enable) begin
            state    <= StIdle;
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            outDataQ <= centre;
            runningQ <= 1'b0;
         end else begin
            if (doPush) begin
               wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
               rdPtr      <= rdPtr + 1'b1;
               outDataQ   <= mem[rdPtr];
               outStrobeQ <= 1'b1;
            end
            if (doPush && !doPop) begin
               count <= count + 1'b1;
            end else if (!doPush && doPop) begin
               count <= count - 1'b1;
            end

            unique case (state)
               StIdle: begin
                  state <= StPrefill;
               end
               StPrefill: begin
                  if (count >= prefillLvl) begin
                     state    <= StRun;
                     runningQ <= 1'b1;
                  end
               end
               StRun: begin
                  if (setUnder) begin
                     state    <= StPrefill;
                     runningQ <= 1'b0;
                  end
               end
               default: begin
                  state    <= StIdle;
                  runningQ <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.outData   = outDataQ;
   assign bus.outStrobe = outStrobeQ;
   assign bus.level     = count;
   assign bus.underrun  = underrunQ;
   assign bus.overflow  = overflowQ;
   assign bus.running   = runningQ;
endmodule

// File: tb/tb_sample_scheduler.sv
// Self-checking bench for sample_scheduler: directed scenarios plus a randomized run,
// all compared against a queue-based behavioural model.
module tb_sample_scheduler;
   localparam int unsigned DIV    = 4;
   localparam int unsigned DB     = 3;
   localparam int unsigned DEPTH  = 8;
   localparam int unsigned PRE    = 4;
   localparam int unsigned W      = 24;
   localparam logic [W-1:0] CENTRE = 24'h800000;
   localparam logic [W-1:0] MARKER = 24'hABCDEF;
   localparam int MIdle = 0;
   localparam int MPre  = 1;
   localparam int MRun  = 2;

   logic clk = 1'b0;
   logic reset;

   sample_scheduler_if #(.W(W), .depthBits(DB)) bus ();

   sample_scheduler #(
      .clockRate    (192_000),
      .sampleRate   (48_000),
      .blockSize    (3),
      .depthBits    (DB),
      .prefillLevel (PRE)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int nChecks = 0;
   int nFails  = 0;

   // Behavioural model state
   logic [W-1:0] mq[$];
   int           mMode;
   int           mCnt;
   logic [W-1:0] mOut;
   logic         mStrobe;
   logic         mUnd;
   logic         mOvf;

   // Drive one clock of inputs, advance the model, and settle 1 time unit after the edge.
   task automatic cycle(input logic en, input logic av, input logic [W-1:0] d,
                        input logic clr, input logic rst);
      int pre;
      bit tk, pop, setU, setO;
      bus.enable      = en;
      bus.inAvailable = av;
      bus.inData      = d;
      bus.clearFlags  = clr;
      reset           = rst;
      @(posedge clk);
      if (!rst) begin
         mMode = MIdle; mq.delete(); mCnt = 0; mOut = CENTRE;
         mStrobe = 0; mUnd = 0; mOvf = 0;
      end else begin
         pre  = mq.size();
         tk   = (mCnt % DIV) == DIV - 1;
         mCnt++;
         pop  = (mMode == MRun) && tk && pre > 0;
         setU = (mMode == MRun) && tk && pre == 0;
         setO = av && (mMode != MIdle) && pre == DEPTH && !pop;
         if (clr) begin mUnd = 0; mOvf = 0; end
         if (setU) mUnd = 1;
         if (setO) mOvf = 1;
         mStrobe = 0;
         if (!en) begin
            mMode = MIdle; mq.delete(); mOut = CENTRE;
         end else begin
            if (pop) begin mOut = mq.pop_front(); mStrobe = 1; end
            if (av && mMode != MIdle && (pre < DEPTH || pop)) mq.push_back(d);
            case (mMode)
               MIdle:   mMode = MPre;
               MPre:    if (pre >= PRE) mMode = MRun;
               default: if (setU) mMode = MPre;
            endcase
         end
      end
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++)
         cycle(1'($urandom()), 1'($urandom()), W'($urandom()), 1'($urandom()), 1'b0);
      nChecks++;
      if (bus.outData !== CENTRE) begin
         $display("FAIL reset outData: got %h want %h", bus.outData, CENTRE); nFails++;
      end
      nChecks++;
      if (bus.level !== '0) begin
         $display("FAIL reset level: got %0d want 0", bus.level); nFails++;
      end
      nChecks++;
      if (bus.underrun !== 1'b0 || bus.overflow !== 1'b0) begin
         $display("FAIL reset flags: got u=%b o=%b want 0 0", bus.underrun, bus.overflow);
         nFails++;
      end
      nChecks++;
      if (bus.running !== 1'b0 || bus.outStrobe !== 1'b0) begin
         $display("FAIL reset run/strobe: got r=%b s=%b want 0 0", bus.running, bus.outStrobe);
         nFails++;
      end
   endtask

   task automatic test_prefill_run();
      int got = 0;
      int last = -1;
      cycle(1, 0, '0, 0, 1);
      for (int i = 1; i <= 4; i++) cycle(1, 1, W'(i), 0, 1);
      nChecks++;
      if (bus.level !== 4 || bus.running !== 1'b0) begin
         $display("FAIL prefill level/running: got %0d/%b want 4/0", bus.level, bus.running);
         nFails++;
      end
      for (int i = 0; i < 40 && got < 4; i++) begin
         cycle(1, 0, '0, 0, 1);
         if (i == 0) begin
            nChecks++;
            if (bus.running !== 1'b1) begin
               $display("FAIL run entry running: got %b want 1", bus.running); nFails++;
            end
         end
         if (bus.outStrobe === 1'b1) begin
            got++;
            nChecks++;
            if (bus.outData !== W'(got) || bus.outData !== mOut) begin
               $display("FAIL run data #%0d: got %h want %h", got, bus.outData, W'(got));
               nFails++;
            end
            if (last >= 0) begin
               nChecks++;
               if (i - last != DIV) begin
                  $display("FAIL strobe spacing: got %0d want %0d", i - last, DIV); nFails++;
               end
            end
            last = i;
         end
      end
      nChecks++;
      if (got != 4) begin
         $display("FAIL run strobe count: got %0d want 4", got); nFails++;
      end
   endtask

   task automatic test_underrun();
      for (int i = 0; i < 3; i++) cycle(1, 0, '0, 0, 1);
      nChecks++;
      if (bus.underrun !== 1'b0) begin
         $display("FAIL underrun early: got %b want 0", bus.underrun); nFails++;
      end
      cycle(1, 0, '0, 0, 1);
      nChecks++;
      if (bus.underrun !== 1'b1 || bus.outData !== 24'h000004 || bus.running !== 1'b0) begin
         $display("FAIL underrun state: got u=%b d=%h r=%b want 1 000004 0",
                  bus.underrun, bus.outData, bus.running);
         nFails++;
      end
      for (int i = 5; i <= 8; i++) cycle(1, 1, W'(i), 0, 1);
      cycle(1, 0, '0, 1, 1);
      nChecks++;
      if (bus.running !== 1'b1 || bus.underrun !== 1'b0) begin
         $display("FAIL resume: got r=%b u=%b want 1 0", bus.running, bus.underrun); nFails++;
      end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 12; i++) begin
         cycle(1, 1, W'(24'h000100 + i), 0, 1);
         nChecks++;
         if (bus.level !== 4'(mq.size()) || bus.overflow !== mOvf) begin
            $display("FAIL overflow fill %0d: got l=%0d o=%b want %0d %b",
                     i, bus.level, bus.overflow, mq.size(), mOvf);
            nFails++;
         end
      end
      nChecks++;
      if (bus.level !== 8 || bus.overflow !== 1'b1) begin
         $display("FAIL overflow final: got l=%0d o=%b want 8 1", bus.level, bus.overflow);
         nFails++;
      end
      if ((mCnt % DIV) == DIV - 1) cycle(1, 1, 24'h0001F0, 0, 1);
      cycle(1, 1, 24'h0001F1, 1, 1);
      nChecks++;
      if (bus.overflow !== 1'b1 || bus.level !== 8) begin
         $display("FAIL set beats clear: got o=%b l=%0d want 1 8", bus.overflow, bus.level);
         nFails++;
      end
      cycle(1, 0, '0, 1, 1);
      nChecks++;
      if (bus.overflow !== 1'b0) begin
         $display("FAIL clearFlags overflow: got %b want 0", bus.overflow); nFails++;
      end
   endtask

   task automatic test_full_pushpop();
      int got = 0;
      for (int i = 0; i < 8 && (mCnt % DIV) != DIV - 1; i++)
         cycle(1, 1'(mq.size() < DEPTH), 24'h000200 + W'(i), 0, 1);
      nChecks++;
      if (bus.level !== 8 || (mCnt % DIV) != DIV - 1) begin
         $display("FAIL pushpop setup: got level %0d want 8", bus.level); nFails++;
      end
      cycle(1, 1, MARKER, 0, 1);
      nChecks++;
      if (bus.level !== 8 || bus.overflow !== 1'b0 || bus.outStrobe !== 1'b1) begin
         $display("FAIL pushpop at full: got l=%0d o=%b s=%b want 8 0 1",
                  bus.level, bus.overflow, bus.outStrobe);
         nFails++;
      end
      for (int i = 0; i < 60 && got < 8; i++) begin
         cycle(1, 0, '0, 0, 1);
         if (bus.outStrobe === 1'b1) begin
            got++;
            nChecks++;
            if (bus.outData !== mOut || (got == 8) !== (bus.outData === MARKER)) begin
               $display("FAIL drain #%0d: got %h want %h", got, bus.outData,
                        (got == 8) ? MARKER : mOut);
               nFails++;
            end
         end
      end
      nChecks++;
      if (got != 8) begin
         $display("FAIL drain strobe count: got %0d want 8", got); nFails++;
      end
   endtask

   task automatic test_enable_drop();
      bit ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
         cycle(1, 1'(mq.size() < 5), W'($urandom()), 0, 1);
         ok = (mMode == MRun) && (mq.size() == 5);
      end
      nChecks++;
      if (!ok || bus.level !== 5 || bus.running !== 1'b1) begin
         $display("FAIL enable-drop setup: got l=%0d r=%b want 5 1", bus.level, bus.running);
         nFails++;
      end
      cycle(0, 1, 24'h123456, 0, 1);
      nChecks++;
      if (bus.level !== 0 || bus.outData !== CENTRE || bus.running !== 1'b0) begin
         $display("FAIL enable drop: got l=%0d d=%h r=%b want 0 800000 0",
                  bus.level, bus.outData, bus.running);
         nFails++;
      end
      nChecks++;
      if (bus.underrun !== mUnd || bus.overflow !== mOvf) begin
         $display("FAIL flags retained: got u=%b o=%b want %b %b",
                  bus.underrun, bus.overflow, mUnd, mOvf);
         nFails++;
      end
      cycle(1, 1, 24'h111111, 0, 1);
      nChecks++;
      if (bus.level !== 0 || bus.running !== 1'b0) begin
         $display("FAIL idle drop push: got l=%0d r=%b want 0 0", bus.level, bus.running);
         nFails++;
      end
      cycle(1, 1, 24'h222222, 0, 1);
      nChecks++;
      if (bus.level !== 1 || bus.outData !== CENTRE) begin
         $display("FAIL re-enable prefill: got l=%0d d=%h want 1 800000",
                  bus.level, bus.outData);
         nFails++;
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 800; i++) begin
         logic rst, en, av, clr;
         rst = ($urandom_range(99) != 0);
         en  = ($urandom_range(49) != 0);
         av  = (i < 400) ? ($urandom_range(1) == 1) : ($urandom_range(4) == 0);
         clr = ($urandom_range(19) == 0);
         cycle(en, av, W'($urandom()), clr, rst);
         nChecks++;
         if (bus.outData !== mOut || bus.outStrobe !== mStrobe ||
             bus.level !== 4'(mq.size()) || bus.underrun !== mUnd ||
             bus.overflow !== mOvf || bus.running !== (mMode == MRun)) begin
            $display("FAIL random cycle %0d: got d=%h s=%b l=%0d u=%b o=%b r=%b want %h %b %0d %b %b %b",
                     i, bus.outData, bus.outStrobe, bus.level, bus.underrun, bus.overflow,
                     bus.running, mOut, mStrobe, mq.size(), mUnd, mOvf, mMode == MRun);
            nFails++;
         end
      end
   endtask

   initial begin
      reset           = 1'b0;
      bus.enable      = 1'b0;
      bus.inAvailable = 1'b0;
      bus.inData      = '0;
      bus.clearFlags  = 1'b0;
      test_reset();
      test_prefill_run();
      test_underrun();
      test_overflow();
      test_full_pushpop();
      test_enable_drop();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end
endmodule

// File: doc/sample_scheduler.md
Name: sample_scheduler

Overview:
- Sits between the deserializer and the carrier phase-increment register in the FM transmitter.
- Absorbs bursty 24-bit samples arriving from UART via the deserializer into a FIFO. Releases them to the modulator at a fixed sample rate derived from the clock.
- Handles prefill, underrun recovery, overflow detection and idle/centre-frequency output.

Parameters:
- clockRate, 76_800_000, clk frequency in Hz
- sampleRate, 48_000, output sample rate in Hz; divider = clockRate / sampleRate (integer, ≥2)
- blockSize, 3, bytes per sample; sample width W = 8*blockSize
- depthBits, 4, FIFO depth = 2^depthBits entries
- prefillLevel, 8, FIFO level required to leave PREFILL (1..2^depthBits)

Ports:
- clk  in  1  system clock (slow clock domain)
- reset  in  1  synchronous, active-low reset
- enable  in  1  1 = stream active; 0 = force IDLE and flush
- inAvailable  in  1  one-cycle strobe: inData valid
- inData  in  W  sample from deserializer
- clearFlags  in  1  one-cycle strobe clearing sticky flags
- outData  out  W  sample driving the phase-delta adder
- outStrobe  out  1  one-cycle pulse when outData takes a new FIFO value
- level  out  depthBits+1  current FIFO occupancy
- underrun  out  1  sticky underrun flag
- overflow  out  1  sticky overflow flag
- running  out  1  1 while state = RUN

Behaviour:
- All registers update on posedge clk. reset sampled low forces:
  - state IDLE, FIFO empty, level 0, tick counter 0
  - outData = centre = 1 << (W-1), i.e. 24'h800000 for W=24
  - outStrobe 0, underrun 0, overflow 0, running 0
- Tick generator:
  - counter runs 0..divider-1 and wraps; tick = (counter == divider-1).
  - Counter free-runs in every state except reset, so tick spacing is exactly divider cycles.
- FIFO:
  - Circular buffer with depthBits-wide read/write pointers and level counter.
  - Push when inAvailable && state != IDLE && (level < depth || pop this cycle).
  - inAvailable while full and not popping: sample dropped, overflow <= 1.
  - inAvailable in IDLE: sample dropped, no flag.
  - Simultaneous push and pop: level unchanged; pointers both advance and wrap modulo depth.
- States:
  - IDLE: outData = centre. enable=1 -> PREFILL next cycle.
  - PREFILL: accepts pushes; outData holds its current value; no pops. level ≥ prefillLevel -> RUN next cycle.
  - RUN: on tick with level > 0, pop head; outData <= head and outStrobe = 1 in the cycle after the tick (latency 1). On tick with level == 0: no pop, outData holds last value, underrun <= 1, state -> PREFILL.
- enable=0 in any state: next cycle state IDLE, FIFO flushed (pointers and level 0), outData = centre. Sticky flags are retained.
- clearFlags: clears underrun and overflow. If a new set condition occurs in the same cycle, set wins.
- running = (state == RUN), registered.
- Reset asserted mid-stream overrides all other inputs in that cycle.

Test Plan:
- Reset: reset=0 for 2 cycles with random inputs -> outData=24'h800000, level=0, all flags 0, running=0.
- Prefill and run (divider=4, depth=8, prefill=4): enable=1, push 0x000001..0x000004 back-to-back -> running rises 1 cycle after level hits 4; outStrobe pulses every 4 cycles with outData 0x000001, 0x000002, … in order.
- Underrun: after the 4 samples are drained, no more pushes -> next tick sets underrun=1, outData holds 0x000004, state PREFILL; pushing 4 more resumes RUN.
- Overflow: in PREFILL with prefill=8, push 9 samples -> level=8, overflow=1, 9th sample never appears at outData; clearFlags -> overflow=0.
- Simultaneous push/pop at full: level=8 in RUN, push on the tick cycle -> level stays 8, no overflow, pushed sample emerges 8 ticks later.
- enable drop: deassert enable mid-RUN with level=5 -> next cycle level=0, outData=24'h800000, running=0; re-enable restarts in PREFILL.
